// File: rtl/regfile_pkg.sv
// regfile_pkg: shared definitions for the register-file write path.
//   REG_AW / REG_NUM : register index width / register count
//   reg_idx_t        : binary register index
//   reg_onehot_t     : one-hot register write-enable vector
//   REQ_WB / REQ_MC  : requester ids (write-back, multi-cycle unit)
package regfile_pkg;
  localparam int REG_AW  = 5;
  localparam int REG_NUM = 32;
  localparam int NUM_REQ = 2;

  typedef logic [REG_AW-1:0]  reg_idx_t;
  typedef logic [REG_NUM-1:0] reg_onehot_t;

  localparam int REQ_WB = 0;
  localparam int REQ_MC = 1;
endpackage

// File: rtl/regidx_onehot.sv
// regidx_onehot: combinational 5-bit index to 32-bit one-hot decode.
//   idx    in  REG_AW   register index
//   onehot out REG_NUM  exactly bit idx set; unknown index gives all-zero
module regidx_onehot
  import regfile_pkg::*;
(
  input  logic [REG_AW-1:0]  idx,
  output logic [REG_NUM-1:0] onehot
);

  // The if-form (rather than a direct compare per bit) makes an X index
  // fall through to zero in simulation instead of smearing X on the enables.
  always_comb begin
    onehot = '0;
    for (int k = 0; k < REG_NUM; k++) begin
      if (idx == reg_idx_t'(k)) onehot[k] = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_wport_arb.sv
// regfile_wport_arb: write-port arbiter/sequencer for the 32-entry register
// file. Two producers (0: write-back, 1: multi-cycle unit) each own one
// holding entry; one entry is granted per cycle and turned into a registered
// one-hot write enable plus data.
//   clk, resetn        clock; synchronous active-low reset
//   req_valid/ready    per-requester handshake (bit i = requester i)
//   req_addr0/1        destination register index
//   req_data0/1        write data
//   rf_we              registered one-hot write enable (index 0 never enabled)
//   rf_waddr/rf_wdata  index/data of the write in flight (hold when idle)
//   busy               a holding entry is occupied or a write is in flight
// Build option: REGFILE_WPORT_RR_EN selects round-robin on contention;
// without it requester 0 has fixed priority.
module regfile_wport_arb
  import regfile_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [NUM_REQ-1:0]  req_valid,
  output logic [NUM_REQ-1:0]  req_ready,
  input  logic [REG_AW-1:0]   req_addr0,
  input  logic [REG_AW-1:0]   req_addr1,
  input  logic [DW-1:0]       req_data0,
  input  logic [DW-1:0]       req_data1,
  output logic [REG_NUM-1:0]  rf_we,
  output logic [REG_AW-1:0]   rf_waddr,
  output logic [DW-1:0]       rf_wdata,
  output logic                busy
);

  logic [NUM_REQ-1:0]             hold_v, grant, acc;
  logic [NUM_REQ-1:0][REG_AW-1:0] hold_addr, in_addr;
  logic [NUM_REQ-1:0][DW-1:0]     hold_data, in_data;
  logic                           gnt_sel;
  reg_idx_t                       gnt_addr;
  logic [DW-1:0]                  gnt_data;
  reg_onehot_t                    gnt_oh;

  assign in_addr = {req_addr1, req_addr0};
  assign in_data = {req_data1, req_data0};

  // Arbitration only looks at the holding entries, so a new request always
  // spends one cycle in its entry before it can be granted.
`ifdef REGFILE_WPORT_RR_EN
  logic rr_ptr;

  always_comb begin
    grant = '0;
    case (hold_v)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = rr_ptr ? 2'b10 : 2'b01;
      default: grant = '0;
    endcase
  end

  // Contention always grants the pointed-to side, so flipping on every
  // contended cycle hands the next contended grant to the other requester.
  always_ff @(posedge clk) begin
    if (!resetn)      rr_ptr <= 1'b0;
    else if (&hold_v) rr_ptr <= ~rr_ptr;
  end
`else
  assign grant[REQ_WB] = hold_v[REQ_WB];
  assign grant[REQ_MC] = hold_v[REQ_MC] & ~hold_v[REQ_WB];
`endif

  // A granted entry drains this edge, so it can be refilled in the same edge.
  assign req_ready = ~hold_v | grant;
  assign acc       = req_valid & req_ready;

  assign gnt_sel  = grant[REQ_MC];
  assign gnt_addr = hold_addr[gnt_sel];
  assign gnt_data = hold_data[gnt_sel];

  regidx_onehot u_onehot (
    .idx    (gnt_addr),
    .onehot (gnt_oh)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      hold_v    <= '0;
      hold_addr <= '0;
      hold_data <= '0;
      rf_we     <= '0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (acc[i]) begin
          hold_v[i]    <= 1'b1;
          hold_addr[i] <= in_addr[i];
          hold_data[i] <= in_data[i];
        end else if (grant[i]) begin
          hold_v[i]    <= 1'b0;
        end
      end
      if (|grant) begin
        // $zero consumes its slot and shows on rf_waddr but never writes.
        rf_we    <= (gnt_addr == '0) ? '0 : gnt_oh;
        rf_waddr <= gnt_addr;
        rf_wdata <= gnt_data;
      end else begin
        rf_we    <= '0;
      end
    end
  end

  assign busy = (|hold_v) | (|rf_we);

endmodule

// File: tb/tb_regfile_wport_arb.sv
module tb_regfile_wport_arb;
  logic        clk = 1'b0;
  logic        resetn;
  logic [1:0]  req_valid, req_ready;
  logic [4:0]  req_addr0, req_addr1;
  logic [31:0] req_data0, req_data1;
  logic [31:0] rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        busy;

  regfile_wport_arb #(.DW(32)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_data0(req_data0), .req_data1(req_data1),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic        who;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] exp_we;
  } vec_t;

  typedef struct {
    int          cyc;
    logic [31:0] we;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input logic [31:0] we, input logic [4:0] a, input logic [31:0] d);
    exp_t e;
    e.cyc = c; e.we = we; e.addr = a; e.data = d;
    q.push_back(e);
  endtask

  // Scoreboard: a write is expected exactly in its listed cycle; any other
  // cycle must show no write enable.
  always @(negedge clk) begin : mon
    exp_t e;
    if (mon_en) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        checks++;
        errors++;
        $display("FAIL missed_write: expected we %h at cyc %0d, now cyc %0d", e.we, e.cyc, cyc);
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        chk("rf_we", rf_we, e.we);
        chk("rf_waddr", 32'(rf_waddr), 32'(e.addr));
        chk("rf_wdata", rf_wdata, e.data);
      end else begin
        chk("idle_rf_we", rf_we, 32'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        vecs[6];
    logic [1:0]  rdy_exp[4];
    logic [31:0] d;
    int          base;

    vecs[0] = '{1'b0, 5'd5,  32'hDEADBEEF, 32'h0000_0020};
    vecs[1] = '{1'b1, 5'd0,  32'h1234_5678, 32'h0000_0000};
    vecs[2] = '{1'b1, 5'd31, 32'hCAFE_F00D, 32'h8000_0000};
    vecs[3] = '{1'b0, 5'd1,  32'h1111_1111, 32'h0000_0002};
    vecs[4] = '{1'b1, 5'd16, 32'hA5A5_A5A5, 32'h0001_0000};
    vecs[5] = '{1'b0, 5'd0,  32'h0BAD_F00D, 32'h0000_0000};

    // Reset with both requesters asserting: nothing may be captured.
    resetn = 1'b0; req_valid = 2'b11;
    req_addr0 = 5'd3; req_addr1 = 5'd4;
    req_data0 = 32'h3333_3333; req_data1 = 32'h4444_4444;
    repeat (3) tick();
    resetn = 1'b1; req_valid = 2'b00;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'h3);
    chk("rst_we", rf_we, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_waddr", 32'(rf_waddr), 32'h0);
    chk("rst_wdata", rf_wdata, 32'h0);
    tick();
    mon_en = 1'b1;
    tick();
    chk("post_rst_busy", 32'(busy), 32'h0);

    // Table: single-requester writes, back to back, never contended.
    for (int j = 0; j < 6; j++) begin
      req_valid = vecs[j].who ? 2'b10 : 2'b01;
      if (vecs[j].who) begin req_addr1 = vecs[j].addr; req_data1 = vecs[j].data; end
      else             begin req_addr0 = vecs[j].addr; req_data0 = vecs[j].data; end
      push(cyc + 2, vecs[j].exp_we, vecs[j].addr, vecs[j].data);
      tick();
    end
    req_valid = 2'b00;
    repeat (4) tick();

    // Requester 1 to $zero: slot used, no enable, busy clears afterwards.
    req_valid = 2'b10; req_addr1 = 5'd0; req_data1 = 32'h0000_0077;
    push(cyc + 2, 32'h0, 5'd0, 32'h0000_0077);
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    @(negedge clk);
    chk("zero_busy_clear", 32'(busy), 32'h0);
    tick();

    // Sustained stream from requester 0 over every index.
    for (int k = 0; k < 32; k++) begin
      d = 32'h5A5A_0000 ^ (32'(k) * 32'h0101_0101);
      req_valid = 2'b01; req_addr0 = 5'(k); req_data0 = d;
      push(cyc + 2, (k == 0) ? 32'h0 : (32'h1 << k), 5'(k), d);
      @(negedge clk);
      chk("stream_ready0", 32'(req_ready[0]), 32'h1);
      tick();
    end
    req_valid = 2'b00;
    repeat (4) tick();

    // Contention: both requesters hold valid for 4 cycles.
    base = cyc;
`ifdef REGFILE_WPORT_RR_EN
    rdy_exp = '{2'b11, 2'b01, 2'b10, 2'b01};
    push(base + 2, 32'h0000_0002, 5'd1,  32'hA000_0000);
    push(base + 3, 32'h8000_0000, 5'd31, 32'hB000_0000);
    push(base + 4, 32'h0000_0002, 5'd1,  32'hA000_0001);
    push(base + 5, 32'h8000_0000, 5'd31, 32'hB000_0002);
    push(base + 6, 32'h0000_0002, 5'd1,  32'hA000_0003);
`else
    rdy_exp = '{2'b11, 2'b01, 2'b01, 2'b01};
    push(base + 2, 32'h0000_0002, 5'd1,  32'hA000_0000);
    push(base + 3, 32'h0000_0002, 5'd1,  32'hA000_0001);
    push(base + 4, 32'h0000_0002, 5'd1,  32'hA000_0002);
    push(base + 5, 32'h0000_0002, 5'd1,  32'hA000_0003);
    push(base + 6, 32'h8000_0000, 5'd31, 32'hB000_0000);
`endif
    for (int k = 0; k < 4; k++) begin
      req_valid = 2'b11;
      req_addr0 = 5'd1;  req_data0 = 32'hA000_0000 + 32'(k);
      req_addr1 = 5'd31; req_data1 = 32'hB000_0000 + 32'(k);
      @(negedge clk);
      chk("contend_ready", 32'(req_ready), 32'(rdy_exp[k]));
      tick();
    end
    req_valid = 2'b00;
    repeat (5) tick();
    @(negedge clk);
    chk("contend_busy_clear", 32'(busy), 32'h0);
    tick();

    // Reset while both entries are full: pending writes must be dropped.
    req_valid = 2'b11;
    req_addr0 = 5'd7; req_data0 = 32'h7777_7777;
    req_addr1 = 5'd9; req_data1 = 32'h9999_9999;
    tick();
    @(negedge clk);
    chk("full_busy", 32'(busy), 32'h1);
    resetn = 1'b0; req_valid = 2'b00;
    tick();
    @(negedge clk);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_ready", 32'(req_ready), 32'h3);
    chk("mid_rst_waddr", 32'(rf_waddr), 32'h0);
    chk("mid_rst_wdata", rf_wdata, 32'h0);
    resetn = 1'b1;
    repeat (6) tick();
    @(negedge clk);
    chk("post_rst_idle_busy", 32'(busy), 32'h0);

    tick();
    chk("sb_empty", 32'(q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
